debounce_edge: RTL and testbench

Conditions a raw, asynchronous, possibly bouncing input (push-button or switch) into a clean, clock-synchronous level plus single-cycle rise/fall strobes. Sits directly upstream of the sequential storage blocks (`d_ff` and friends): `dout` drives their `D` input, and the strobes act as clean enables or toggles. Contents: a 2-flop synchronizer, a stability counter and a 4-state debounce FSM.

---
 rtl/debounce_edge.sv | 124 ++++++++++++
 tb/tb_debounce_edge.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
// Debounces a raw asynchronous input: 2-flop synchronizer, stability counter
// and a 4-state qualification FSM producing a clean level plus rise/fall strobes.
module debounce_edge #(
  parameter int STABLE_COUNT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1;
  logic                 s2;
  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 dout_nxt;
  logic                 rise_nxt;
  logic                 fall_nxt;
  logic                 busy_nxt;

  // Stage: synchronizer; the FSM only ever looks at s2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Stage: qualification FSM next-state and registered-output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LO: begin
        cnt_nxt = '0;
        if (s2) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          dout_nxt  = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        cnt_nxt = '0;
        if (!s2) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          dout_nxt  = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
        dout_nxt  = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
  end

  // Stage: state and output registers; busy always tracks the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STABLE_LO;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dout  <= dout_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge with default parameters and a 10 ns clock.
module tb_debounce_edge;

  logic clk;
  logic reset;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  int checks   = 0;
  int failures = 0;

  debounce_edge #(.STABLE_COUNT(4), .CNT_WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic d, input logic r,
                           input logic f, input logic b);
    check({tag, ".dout"}, dout, d);
    check({tag, ".rise"}, rise, r);
    check({tag, ".fall"}, fall, f);
    check({tag, ".busy"}, busy, b);
  endtask

  // Called just after din moves to 1; the next edge is the capturing edge k.
  task automatic capture_rise(input string tag);
    tick();
    check({tag, ".k.dout"}, dout, 1'b0);
    check({tag, ".k.rise"}, rise, 1'b0);
    tick();
    check({tag, ".k1.dout"}, dout, 1'b0);
    check({tag, ".k1.rise"}, rise, 1'b0);
    for (int j = 2; j <= 4; j++) begin
      tick();
      check_all($sformatf("%s.k%0d", tag, j), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    check_all({tag, ".k5"}, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_all({tag, ".k6"}, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic capture_fall(input string tag);
    tick();
    check({tag, ".k.dout"}, dout, 1'b1);
    check({tag, ".k.fall"}, fall, 1'b0);
    tick();
    check({tag, ".k1.dout"}, dout, 1'b1);
    check({tag, ".k1.fall"}, fall, 1'b0);
    for (int j = 2; j <= 4; j++) begin
      tick();
      check_all($sformatf("%s.k%0d", tag, j), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    tick();
    check_all({tag, ".k5"}, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_all({tag, ".k6"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drive a high pulse of 'width' cycles from STABLE_LO and check every edge
  // against a hand-derived schedule: the FSM sees capture edge i at edge i+2.
  task automatic pulse(input string tag, input int width, input int n_ticks);
    logic ed, er, ef, eb;
    for (int i = 0; i < n_ticks; i++) begin
      din = (i < width) ? 1'b1 : 1'b0;
      tick();
      if (width >= 4) begin
        ed = (i >= 5) && (i < width + 5);
        er = (i == 5);
        ef = (i == width + 5);
        eb = ((i >= 2) && (i <= 4)) || ((i >= width + 2) && (i <= width + 4));
      end else begin
        ed = 1'b0;
        er = 1'b0;
        ef = 1'b0;
        eb = (i >= 2) && (i <= width + 1);
      end
      check_all($sformatf("%s.e%0d", tag, i), ed, er, ef, eb);
    end
  endtask

  logic [8:0] bounce_pat;

  initial begin
    reset = 1'b0;
    din   = 1'b1;
    #1;
    check_all("reset.t0", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("reset.c1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("reset.c2", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    capture_rise("reset_rel");

    // Clean step: hold high, then return low
    for (int i = 0; i < 14; i++) begin
      tick();
      check_all($sformatf("hold_hi.%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    din = 1'b0;
    capture_fall("step_fall");

    // Bounce pattern, first value in bit 8
    bounce_pat = 9'b101101110;
    for (int i = 8; i >= 0; i--) begin
      din = bounce_pat[i];
      tick();
      check($sformatf("bounce.%0d.rise", 8 - i), rise, 1'b0);
      check($sformatf("bounce.%0d.dout", 8 - i), dout, 1'b0);
    end
    din = 1'b1;
    capture_rise("bounce_rise");
    din = 1'b0;
    capture_fall("bounce_fall");

    // Glitch rejection and minimum propagating pulse
    pulse("glitch3", 3, 10);
    pulse("pulse4", 4, 12);

    // Reset while in WAIT_HI with cnt=2
    din = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_all("wait_hi.cnt2", 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_all("rst_wait.async", 1'b0, 1'b0, 1'b0, 1'b0);
    din = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all($sformatf("rst_wait.hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all($sformatf("rst_wait.after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset while in STABLE_HI
    din = 1'b1;
    capture_rise("pre_rst_hi");
    tick();
    check("stable_hi.dout", dout, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_all("rst_hi.async", 1'b0, 1'b0, 1'b0, 1'b0);
    din = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all($sformatf("rst_hi.hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all($sformatf("rst_hi.after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
